// File: rtl/eth_mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO management master: FSM states,
// register offsets, frame field codes and the frame word builder.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA
    } mdio_state_t;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_RDATA  = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] TA_CODE  = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    // Everything after the preamble, MSB first: ST, OP, PHYAD, REGAD, TA, DATA.
    function automatic logic [31:0] frame_word(
        input logic [1:0]         op,
        input logic [PHYAD_W-1:0] phyad,
        input logic [REGAD_W-1:0] regad,
        input logic [DATA_W-1:0]  wdata
    );
        return {ST_CODE, op, phyad, regad, TA_CODE, wdata};
    endfunction

endpackage

// File: rtl/eth_mdio_clkgen.sv
// MDC generator: each bit is a low phase then a high phase of div+1 clks.
// Held in the low phase with a cleared counter whenever run is low.
module eth_mdio_clkgen (
    input  logic       clk,
    input  logic       srst,
    input  logic       run,
    input  logic [7:0] div,
    output logic       mdc,
    output logic       fall_stb,
    output logic       rise_stb,
    output logic       sample_stb
);

    logic [7:0] cnt_reg;
    logic       phase_reg;
    logic       phase_end;

    assign phase_end = run && (cnt_reg == div);

    always_ff @(posedge clk) begin
        if (srst || !run) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (phase_end) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign mdc        = phase_reg;
    assign rise_stb   = phase_end & ~phase_reg;
    assign sample_stb = phase_end & phase_reg;
    // The edge that closes a high phase opens the next bit's low phase.
    assign fall_stb   = sample_stb;

endmodule

// File: rtl/eth_mdio_master.sv
// Clause 22 MDIO master behind a 4-word Avalon-MM slave: builds the frame,
// drives/samples the MDIO pad and returns PHY read data.
module eth_mdio_master
    import eth_mdio_pkg::*;
#(
    parameter int DIV_RESET    = 24,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    mdio_state_t        state_reg;
    logic [4:0]         bit_cnt_reg;
    logic [31:0]        frame_reg;
    logic               is_read_reg;
    logic [7:0]         div_reg;
    logic [7:0]         div_frame_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               ien_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [DATA_W-1:0]  rshift_reg;
    logic               mdio_out_reg;
    logic               mdio_oe_reg;
    logic [1:0]         sync_reg;

    logic               wr;
    logic               cmd_start;
    logic [31:0]        cmd_frame;
    logic               mdio_sync;
    logic               fall_stb;
    logic               rise_stb;
    logic               sample_stb;
    logic               unused_bits;

    assign wr        = chipselect & ~write_n;
    assign cmd_start = wr && (address == ADDR_CMD) && !busy_reg;
    assign cmd_frame = frame_word(writedata[26] ? OP_READ : OP_WRITE,
                                  writedata[25:21], writedata[20:16], writedata[15:0]);
    assign mdio_sync = sync_reg[1];
    assign unused_bits = &{1'b0, writedata[31:27], rise_stb};

    eth_mdio_clkgen u_clkgen (
        .clk        (clk),
        .srst       (reset),
        .run        (busy_reg),
        .div        (div_frame_reg),
        .mdc        (mdc),
        .fall_stb   (fall_stb),
        .rise_stb   (rise_stb),
        .sample_stb (sample_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], mdio_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= '0;
            frame_reg     <= '0;
            is_read_reg   <= 1'b0;
            div_reg       <= 8'(DIV_RESET);
            div_frame_reg <= 8'(DIV_RESET);
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ien_reg       <= 1'b0;
            rdata_reg     <= '0;
            rshift_reg    <= '0;
            mdio_out_reg  <= 1'b1;
            mdio_oe_reg   <= 1'b0;
        end else begin
            if (wr && address == ADDR_DIV) begin
                div_reg <= writedata[7:0];
            end
            if (wr && address == ADDR_STATUS) begin
                ien_reg <= writedata[2];
                if (writedata[1]) begin
                    done_reg <= 1'b0;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    mdio_out_reg <= 1'b1;
                    mdio_oe_reg  <= 1'b0;
                    if (cmd_start) begin
                        // The first low phase begins right here, so outputs load now.
                        is_read_reg   <= writedata[26];
                        frame_reg     <= cmd_frame;
                        div_frame_reg <= div_reg;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        bit_cnt_reg   <= '0;
                        mdio_oe_reg   <= 1'b1;
                        if (PREAMBLE_LEN > 0) begin
                            state_reg    <= S_PRE;
                            mdio_out_reg <= 1'b1;
                        end else begin
                            state_reg    <= S_HDR;
                            mdio_out_reg <= cmd_frame[31];
                        end
                    end
                end
                S_PRE: begin
                    if (fall_stb) begin
                        if (bit_cnt_reg == 5'(PREAMBLE_LEN - 1)) begin
                            state_reg    <= S_HDR;
                            bit_cnt_reg  <= '0;
                            mdio_out_reg <= frame_reg[31];
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (fall_stb) begin
                        frame_reg    <= {frame_reg[30:0], 1'b0};
                        mdio_out_reg <= frame_reg[30];
                        if (bit_cnt_reg == 5'd13) begin
                            state_reg   <= S_TA;
                            bit_cnt_reg <= '0;
                            if (is_read_reg) begin
                                mdio_oe_reg  <= 1'b0;
                                mdio_out_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_TA: begin
                    if (fall_stb) begin
                        frame_reg    <= {frame_reg[30:0], 1'b0};
                        mdio_out_reg <= is_read_reg ? 1'b1 : frame_reg[30];
                        if (bit_cnt_reg == 5'd1) begin
                            state_reg   <= S_DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_stb) begin
                        rshift_reg <= {rshift_reg[DATA_W-2:0], mdio_sync};
                        if (bit_cnt_reg == 5'd15) begin
                            if (is_read_reg) begin
                                rdata_reg <= {rshift_reg[DATA_W-2:0], mdio_sync};
                            end
                            state_reg    <= S_IDLE;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            mdio_oe_reg  <= 1'b0;
                            mdio_out_reg <= 1'b1;
                        end else begin
                            frame_reg    <= {frame_reg[30:0], 1'b0};
                            mdio_out_reg <= is_read_reg ? 1'b1 : frame_reg[30];
                            bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: readdata = {29'd0, ien_reg, done_reg, busy_reg};
            ADDR_RDATA:  readdata = {16'd0, rdata_reg};
            ADDR_DIV:    readdata = {24'd0, div_reg};
            default:     readdata = '0;
        endcase
    end

    assign irq      = done_reg & ien_reg;
    assign mdio_out = mdio_out_reg;
    assign mdio_oe  = mdio_oe_reg;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Directed bench for eth_mdio_master: a 32-bit-preamble instance with a PHY
// read model, plus a preamble-free instance for the suppression case.
module tb_eth_mdio_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        cs0 = 1'b0;
    logic        cs1 = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;

    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1, mdc0, mdc1, out0, out1, oe0, oe1;
    logic        in0 = 1'b1;
    wire logic   mdio_in1;

    logic        phy_bit = 1'b1;
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = 16'd0;
    int          phy_base = 0;

    int total = 0;
    int bad = 0;

    int   rise0 = 0;
    int   rise1 = 0;
    logic mon0_out [256];
    logic mon1_out [256];
    logic mon1_oe  [256];

    always #5 clk = ~clk;

    eth_mdio_master #(.DIV_RESET(24), .PREAMBLE_LEN(32)) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .readdata(rdata1), .irq(irq1),
        .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1), .mdio_in(mdio_in1)
    );

    eth_mdio_master #(.DIV_RESET(24), .PREAMBLE_LEN(0)) u_dut_nopre (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .readdata(rdata0), .irq(irq0),
        .mdc(mdc0), .mdio_out(out0), .mdio_oe(oe0), .mdio_in(in0)
    );

    always @(posedge mdc1) begin
        mon1_out[rise1 % 256] = out1;
        mon1_oe[rise1 % 256]  = oe1;
        rise1 = rise1 + 1;
    end

    always @(posedge mdc0) begin
        mon0_out[rise0 % 256] = out0;
        rise0 = rise0 + 1;
    end

    // PHY turns the bus around and presents each data bit as its low phase opens.
    always @(negedge mdc1) begin
        if ((rise1 - phy_base) >= 48 && (rise1 - phy_base) <= 63)
            phy_bit = phy_data[4'(63 - (rise1 - phy_base))];
        else
            phy_bit = 1'b1;
    end
    assign mdio_in1 = phy_en ? phy_bit : 1'b1;

    task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        if (which == 0) cs0 = 1'b1; else cs1 = 1'b1;
        @(posedge clk);
        #1;
        cs0     = 1'b0;
        cs1     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input int which, input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = (which == 0) ? rdata0 : rdata1;
    endtask

    task automatic wait_idle(input int which, output int cycles);
        logic [31:0] s;
        cycles = 0;
        rd(which, 2'd1, s);
        while (s[0] && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
            rd(which, 2'd1, s);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(1, 2'd3, d);
        total++; if (d !== 32'h18) begin bad++; $display("FAIL reset_div: got %h want %h", d, 32'h18); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
        rd(1, 2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want %h", d, 32'h0); end
        total++; if (mdc1 !== 1'b0) begin bad++; $display("FAIL reset_mdc: got %b want 0", mdc1); end
        total++; if (oe1 !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe1); end
        total++; if (out1 !== 1'b1) begin bad++; $display("FAIL reset_out: got %b want 1", out1); end
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq1); end
        rd(0, 2'd3, d);
        total++; if (d !== 32'h18) begin bad++; $display("FAIL reset_div_nopre: got %h want %h", d, 32'h18); end
        $display("test_reset: checked register and pin reset values");
    endtask

    task automatic test_write();
        logic [31:0] d, w;
        int base, cyc, ones, oes;
        bus_write(1, 2'd3, 32'd0);
        base = rise1;
        bus_write(1, 2'd0, 32'h0021_1140);
        wait_idle(1, cyc);
        ones = 0; oes = 0; w = 0;
        for (int i = 0; i < 32; i++) ones += int'(mon1_out[(base + i) % 256]);
        for (int i = 0; i < 32; i++) w = {w[30:0], mon1_out[(base + 32 + i) % 256]};
        for (int i = 0; i < 64; i++) oes += int'(mon1_oe[(base + i) % 256]);
        total++; if (cyc !== 128) begin bad++; $display("FAIL wr_busy_len: got %0d want 128", cyc); end
        total++; if (rise1 - base !== 64) begin bad++; $display("FAIL wr_pulses: got %0d want 64", rise1 - base); end
        total++; if (ones !== 32) begin bad++; $display("FAIL wr_preamble: got %0d want 32", ones); end
        total++; if (w !== 32'h5086_1140) begin bad++; $display("FAIL wr_bits: got %h want %h", w, 32'h5086_1140); end
        total++; if (oes !== 64) begin bad++; $display("FAIL wr_oe: got %0d want 64", oes); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL wr_done: got %h want %h", d, 32'h2); end
        total++; if ({mdc1, oe1, out1} !== 3'b001) begin bad++; $display("FAIL wr_idle_pins: got %b want 001", {mdc1, oe1, out1}); end
        $display("test_write: cycles=%0d pulses=%0d bits=%h", cyc, rise1 - base, w);
    endtask

    task automatic test_read();
        logic [31:0] d, w;
        int base, cyc, oe_hdr, oe_rest;
        bus_write(1, 2'd3, 32'd1);
        bus_write(1, 2'd1, 32'h4);
        phy_data = 16'h0022;
        base     = rise1;
        phy_base = rise1;
        phy_en   = 1'b1;
        bus_write(1, 2'd0, 32'h0422_0000);
        wait_idle(1, cyc);
        w = 0; oe_hdr = 0; oe_rest = 0;
        for (int i = 0; i < 14; i++) w = {w[30:0], mon1_out[(base + 32 + i) % 256]};
        for (int i = 0; i < 46; i++) oe_hdr += int'(mon1_oe[(base + i) % 256]);
        for (int i = 46; i < 64; i++) oe_rest += int'(mon1_oe[(base + i) % 256]);
        total++; if (cyc !== 256) begin bad++; $display("FAIL rd_busy_len: got %0d want 256", cyc); end
        total++; if (rise1 - base !== 64) begin bad++; $display("FAIL rd_pulses: got %0d want 64", rise1 - base); end
        total++; if (w[13:0] !== 14'b01100000100010) begin bad++; $display("FAIL rd_header: got %b want %b", w[13:0], 14'b01100000100010); end
        total++; if (oe_hdr !== 46) begin bad++; $display("FAIL rd_oe_hdr: got %0d want 46", oe_hdr); end
        total++; if (oe_rest !== 0) begin bad++; $display("FAIL rd_oe_ta_data: got %0d want 0", oe_rest); end
        rd(1, 2'd2, d);
        total++; if (d !== 32'h0022) begin bad++; $display("FAIL rd_rdata: got %h want %h", d, 32'h0022); end
        total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL rd_irq: got %b want 1", irq1); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL rd_status: got %h want %h", d, 32'h6); end
        bus_write(1, 2'd1, 32'h6);
        #1;
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL rd_irq_clear: got %b want 0", irq1); end
        bus_write(1, 2'd1, 32'h0);
        phy_en = 1'b0;
        $display("test_read: cycles=%0d rdata=%h", cyc, d);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, w;
        int base, cyc;
        bus_write(1, 2'd3, 32'd0);
        base = rise1;
        bus_write(1, 2'd0, 32'h0021_1140);
        repeat (40) @(posedge clk);
        bus_write(1, 2'd0, 32'h0422_0000);
        wait_idle(1, cyc);
        w = 0;
        for (int i = 0; i < 32; i++) w = {w[30:0], mon1_out[(base + 32 + i) % 256]};
        total++; if (rise1 - base !== 64) begin bad++; $display("FAIL busy_pulses: got %0d want 64", rise1 - base); end
        total++; if (w !== 32'h5086_1140) begin bad++; $display("FAIL busy_bits: got %h want %h", w, 32'h5086_1140); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL busy_done: got %h want %h", d, 32'h2); end
        bus_write(1, 2'd1, 32'h2);
        repeat (300) @(posedge clk);
        #1;
        rd(1, 2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL busy_no_second: got %h want %h", d, 32'h0); end
        total++; if (rise1 - base !== 64) begin bad++; $display("FAIL busy_no_pulses: got %0d want 64", rise1 - base); end
        rd(1, 2'd2, d);
        total++; if (d !== 32'h0022) begin bad++; $display("FAIL busy_rdata_kept: got %h want %h", d, 32'h0022); end
        $display("test_back_to_back: pulses=%0d bits=%h", rise1 - base, w);
    endtask

    task automatic test_nopre();
        logic [31:0] d, w;
        int base, cyc;
        bus_write(0, 2'd3, 32'd2);
        base = rise0;
        bus_write(0, 2'd0, 32'h0021_1140);
        wait_idle(0, cyc);
        w = 0;
        for (int i = 0; i < 32; i++) w = {w[30:0], mon0_out[(base + i) % 256]};
        total++; if (cyc !== 192) begin bad++; $display("FAIL nopre_len: got %0d want 192", cyc); end
        total++; if (rise0 - base !== 32) begin bad++; $display("FAIL nopre_pulses: got %0d want 32", rise0 - base); end
        total++; if (w !== 32'h5086_1140) begin bad++; $display("FAIL nopre_bits: got %h want %h", w, 32'h5086_1140); end
        rd(0, 2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL nopre_done: got %h want %h", d, 32'h2); end
        total++; if ({mdc0, oe0, out0, irq0} !== 4'b0010) begin bad++; $display("FAIL nopre_pins: got %b want 0010", {mdc0, oe0, out0, irq0}); end
        $display("test_nopre: cycles=%0d pulses=%0d", cyc, rise0 - base);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int base, cyc, n, r;
        bus_write(1, 2'd3, 32'd0);
        phy_data = 16'hBEEF;
        base     = rise1;
        phy_base = rise1;
        phy_en   = 1'b1;
        bus_write(1, 2'd0, 32'h0422_0000);
        n = 0;
        while ((rise1 - base) < 52 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (rise1 - base !== 52) begin bad++; $display("FAIL rst_reach_data: got %0d want 52", rise1 - base); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if ({mdc1, oe1, out1} !== 3'b001) begin bad++; $display("FAIL rst_pins: got %b want 001", {mdc1, oe1, out1}); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want %h", d, 32'h0); end
        @(negedge clk);
        reset  = 1'b0;
        phy_en = 1'b0;
        rd(1, 2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want %h", d, 32'h0); end
        rd(1, 2'd3, d);
        total++; if (d !== 32'h18) begin bad++; $display("FAIL rst_div: got %h want %h", d, 32'h18); end
        r = rise1;
        repeat (50) @(posedge clk);
        #1;
        total++; if (rise1 !== r) begin bad++; $display("FAIL rst_no_pulse: got %0d want %0d", rise1, r); end
        bus_write(1, 2'd3, 32'd0);
        base = rise1;
        bus_write(1, 2'd0, 32'h0021_1140);
        wait_idle(1, cyc);
        total++; if (cyc !== 128) begin bad++; $display("FAIL rst_new_len: got %0d want 128", cyc); end
        total++; if (rise1 - base !== 64) begin bad++; $display("FAIL rst_new_pulses: got %0d want 64", rise1 - base); end
        rd(1, 2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL rst_new_done: got %h want %h", d, 32'h2); end
        $display("test_reset_midframe: recovery cycles=%0d", cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_nopre();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
